car_mileage_display: RTL

//  Parametrised odometer + 7-segment scan driver for the car simulator. Accumulates
//  BCD mileage while the car is powered and moving, and time-multiplexes up to 8

---
 rtl/car_mileage_display_if.sv | 24 ++
 rtl/car_mileage_display.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/car_mileage_display_if.sv
// Bundle between the car controller, the odometer/scan block and the display pins.
// The controller drives mode/state/clear; the odometer returns segments and mileage.
interface car_mileage_display_if #(
    parameter int DIGITS = 8
);
    logic [1:0]          mode;
    logic [1:0]          state;
    logic                clear;
    logic [7:0]          seg_en;
    logic [7:0]          seg0;
    logic [7:0]          seg1;
    logic [4*DIGITS-1:0] mileage_bcd;
    logic                overflow;

    modport master (
        output mode, state, clear,
        input  seg_en, seg0, seg1, mileage_bcd, overflow
    );

    modport slave (
        input  mode, state, clear,
        output seg_en, seg0, seg1, mileage_bcd, overflow
    );
endinterface

// File: rtl/car_mileage_display.sv
// BCD odometer that counts while the car is powered and moving, plus a
// time-multiplexed 7-segment scan driver over two 4-digit segment buses.
module car_mileage_display #(
    parameter int DIGITS   = 8,
    parameter int TICK_DIV = 4,
    parameter int SCAN_DIV = 2,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    car_mileage_display_if.slave  bus
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SLOTS  = 1 << IDX_W;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] mileage_reg;
    logic [4*DIGITS-1:0] mileage_next;
    logic                overflow_reg;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic [SCAN_W-1:0]   scan_cnt_reg;
    logic [IDX_W-1:0]    scan_idx_reg;
    logic [7:0]          seg_en_reg;
    logic [7:0]          seg0_reg;
    logic [7:0]          seg1_reg;

    logic                powered;
    logic                moving;
    logic [DIGITS:0]     carry;
    logic [DIGITS:0]     zero_from;
    logic [3:0]          digit_slot [SLOTS];
    logic [SLOTS-1:0]    lead_zero;
    logic [3:0]          idx_ext;
    logic [7:0]          code;
    logic                show;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hFC;
            4'd1:    c = 8'h60;
            4'd2:    c = 8'hDA;
            4'd3:    c = 8'hF2;
            4'd4:    c = 8'h66;
            4'd5:    c = 8'hB6;
            4'd6:    c = 8'hBE;
            4'd7:    c = 8'hE0;
            4'd8:    c = 8'hFE;
            4'd9:    c = 8'hF6;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    assign powered = (bus.mode != 2'b00);
    assign moving  = powered && (bus.state == 2'b10 || bus.state == 2'b11);

    // Increment is a ripple carry seeded with 1; carry out of the top digit is the wrap.
    assign carry[0]          = 1'b1;
    assign zero_from[DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            assign cur                     = mileage_reg[4*gi +: 4];
            assign carry[gi+1]             = carry[gi] & (cur == 4'd9);
            assign mileage_next[4*gi +: 4] = !carry[gi]     ? cur :
                                             (cur == 4'd9)  ? 4'd0 : cur + 4'd1;
            assign zero_from[gi]           = zero_from[gi+1] & (cur == 4'd0);
        end

        // Pad the digit mux to a power of two so the scan index selects it directly.
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < DIGITS) begin : g_used
                assign digit_slot[gi] = mileage_reg[4*gi +: 4];
                assign lead_zero[gi]  = (gi != 0) && zero_from[gi];
            end else begin : g_unused
                assign digit_slot[gi] = 4'd0;
                assign lead_zero[gi]  = 1'b1;
            end
        end
    endgenerate

    assign idx_ext = 4'(scan_idx_reg);
    assign code    = seg_code(digit_slot[scan_idx_reg]);
    assign show    = powered && !((LZ_BLANK != 0) && lead_zero[scan_idx_reg]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mileage_reg  <= '0;
            overflow_reg <= 1'b0;
            tick_cnt_reg <= '0;
        end else if (bus.clear) begin
            mileage_reg  <= '0;
            overflow_reg <= 1'b0;
            tick_cnt_reg <= '0;
        end else if (!moving) begin
            tick_cnt_reg <= '0;
        end else if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_reg <= '0;
            mileage_reg  <= mileage_next;
            if (carry[DIGITS]) begin
                overflow_reg <= 1'b1;
            end
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= '0;
            seg_en_reg   <= 8'd0;
            seg0_reg     <= 8'd0;
            seg1_reg     <= 8'd0;
        end else begin
            seg_en_reg <= show ? (8'd1 << idx_ext) : 8'd0;
            seg0_reg   <= (show && idx_ext < 4'd4)  ? code : 8'd0;
            seg1_reg   <= (show && idx_ext >= 4'd4) ? code : 8'd0;
            if (!powered) begin
                scan_cnt_reg <= '0;
                scan_idx_reg <= '0;
            end else if (scan_cnt_reg == SCAN_LAST) begin
                scan_cnt_reg <= '0;
                scan_idx_reg <= (scan_idx_reg == IDX_LAST) ? '0 : scan_idx_reg + 1'b1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.mileage_bcd = mileage_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.seg_en      = seg_en_reg;
    assign bus.seg0        = seg0_reg;
    assign bus.seg1        = seg1_reg;
endmodule
